// File: rtl/simd_mac_unit.sv
// Multi-cycle INT8x4 SIMD dot-product unit for the CUSTOM-0 instruction, with a saturating
// internal accumulator and optional ReLU. Processes LANES_PER_CYCLE lanes per MUL cycle.
module simd_mac_unit #(
   parameter int LANES_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [2:0]  funct3,
   input  logic        relu_en,
   input  logic [4:0]  rd_in,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_out,
   output logic [31:0] result
);

   localparam int STEPS = 4 / LANES_PER_CYCLE;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   localparam logic [2:0] F_DOT     = 3'b000;
   localparam logic [2:0] F_DOT_ACC = 3'b001;
   localparam logic [2:0] F_CLR_ACC = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [31:0]         r_rs1;
   logic [31:0]         r_rs2;
   logic [2:0]          r_funct3;
   logic                r_relu;
   logic [4:0]          r_rd;
   logic [17:0]         r_psum;
   logic [CW-1:0]       r_lane;
   logic [31:0]         r_acc;
   logic [31:0]         r_result;
   logic [4:0]          r_rd_out;

   logic                w_accept;
   logic                w_is_dot;
   logic                w_last;
   logic signed [15:0]  w_prod [LANES_PER_CYCLE];
   logic [17:0]         w_step;
   logic [17:0]         w_psum_next;
   logic [31:0]         w_sum32;
   logic [32:0]         w_acc_sum;
   logic [31:0]         w_sat;
   logic [31:0]         w_v;
   logic [31:0]         w_res;

   assign w_accept = (r_state == S_IDLE) && start && !flush;
   assign w_is_dot = (funct3 == F_DOT) || (funct3 == F_DOT_ACC);
   assign w_last   = (r_lane == CW'(STEPS - 1));

   // Lane group for this MUL cycle is selected by the lane counter, lowest lanes first.
   for (genvar gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_lane
      logic [1:0]        w_idx;
      logic signed [7:0] w_a;
      logic signed [7:0] w_b;
      assign w_idx      = 2'(r_lane * LANES_PER_CYCLE + gi);
      assign w_a        = 8'(r_rs1 >> {w_idx, 3'b000});
      assign w_b        = 8'(r_rs2 >> {w_idx, 3'b000});
      assign w_prod[gi] = w_a * w_b;
   end

   always_comb begin
      w_step = '0;
      for (int k = 0; k < LANES_PER_CYCLE; k++) begin
         w_step = w_step + {{2{w_prod[k][15]}}, w_prod[k]};
      end
   end

   assign w_psum_next = r_psum + w_step;
   assign w_sum32     = {{14{w_psum_next[17]}}, w_psum_next};
   assign w_acc_sum   = {r_acc[31], r_acc} + {w_sum32[31], w_sum32};

   // 33-bit sum overflows when its two top bits disagree; bit 32 gives the true sign.
   always_comb begin
      w_sat = w_acc_sum[31:0];
      if (w_acc_sum[32] != w_acc_sum[31]) begin
         w_sat = w_acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   always_comb begin
      w_v = '0;
      case (r_funct3)
         F_DOT:     w_v = w_sum32;
         F_DOT_ACC: w_v = w_sat;
         default:   w_v = '0;
      endcase
   end

   assign w_res = (r_relu && w_v[31]) ? 32'h0 : w_v;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_is_dot ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            if (flush) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_funct3 <= '0;
         r_relu   <= 1'b0;
         r_rd     <= '0;
         r_psum   <= '0;
         r_lane   <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rs1    <= rs1_data;
                  r_rs2    <= rs2_data;
                  r_funct3 <= funct3;
                  r_relu   <= relu_en;
                  r_rd     <= rd_in;
                  r_psum   <= '0;
                  r_lane   <= '0;
                  if (!w_is_dot) begin
                     r_result <= '0;
                     r_rd_out <= rd_in;
                     if (funct3 == F_CLR_ACC) begin
                        r_acc <= '0;
                     end
                  end
               end
            end
            S_MUL: begin
               if (!flush) begin
                  r_psum <= w_psum_next;
                  r_lane <= r_lane + CW'(1);
                  if (w_last) begin
                     r_result <= w_res;
                     r_rd_out <= r_rd;
                     if (r_funct3 == F_DOT_ACC) begin
                        r_acc <= w_sat;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // A squash arriving in DONE suppresses the writeback of that result.
   assign done   = (r_state == S_DONE) && !flush;
   assign stall  = w_accept || (r_state == S_MUL);
   assign busy   = (r_state != S_IDLE);
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule

// File: tb/tb_simd_mac_unit.sv
// Bench for simd_mac_unit: three instances (1, 2 and 4 lanes per cycle), a shared scoreboard
// queue filled at issue and drained on done, a vector table and hand-written corner sequences.
module tb_simd_mac_unit;

   localparam int ND = 3;

   logic        clk = 1'b0;
   logic        rst      [ND];
   logic        start    [ND];
   logic        flush    [ND];
   logic [2:0]  f3       [ND];
   logic        relu     [ND];
   logic [4:0]  rd_in    [ND];
   logic [31:0] a        [ND];
   logic [31:0] b        [ND];
   logic        stall    [ND];
   logic        busy     [ND];
   logic        done     [ND];
   logic [4:0]  rd_out   [ND];
   logic [31:0] res      [ND];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      simd_mac_unit #(.LANES_PER_CYCLE(1 << gi)) u_dut (
         .clk      (clk),
         .rst      (rst[gi]),
         .start    (start[gi]),
         .flush    (flush[gi]),
         .funct3   (f3[gi]),
         .relu_en  (relu[gi]),
         .rd_in    (rd_in[gi]),
         .rs1_data (a[gi]),
         .rs2_data (b[gi]),
         .stall    (stall[gi]),
         .busy     (busy[gi]),
         .done     (done[gi]),
         .rd_out   (rd_out[gi]),
         .result   (res[gi])
      );
   end

   typedef struct {
      int          dut;
      logic [4:0]  rd;
      logic [31:0] res;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic        relu;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   exp_t   sbq[$];
   vec_t   tbl[16];
   longint model_acc[ND];
   bit     quiet[ND];
   int     n_cmp = 0;
   int     n_err = 0;

   localparam logic [31:0] T1A = 32'h01020304;
   localparam logic [31:0] T1B = 32'h05060708;

   function automatic int lpc_of(input int d);
      return 1 << d;
   endfunction

   function automatic longint dot4(input logic [31:0] x, input logic [31:0] y);
      longint s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         s += longint'($signed(x[8*i +: 8])) * longint'($signed(y[8*i +: 8]));
      end
      return s;
   endfunction

   // Reference behaviour; updates the modelled accumulator as a side effect.
   function automatic logic [31:0] model(input int d, input logic [2:0] f, input logic r,
                                         input logic [31:0] x, input logic [31:0] y);
      longint v;
      v = 0;
      case (f)
         3'b000: v = dot4(x, y);
         3'b001: begin
            v = model_acc[d] + dot4(x, y);
            if (v > 64'sd2147483647)  v = 64'sd2147483647;
            if (v < -64'sd2147483648) v = -64'sd2147483648;
            model_acc[d] = v;
         end
         3'b010: begin
            model_acc[d] = 0;
            v = 0;
         end
         default: v = 0;
      endcase
      if (r && v < 0) v = 0;
      return v[31:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %08h, want %08h", nm, act, expv);
      end
   endtask

   task automatic push_exp(input int d, input logic [4:0] rd, input logic [31:0] v);
      exp_t e;
      e.dut = d;
      e.rd  = rd;
      e.res = v;
      sbq.push_back(e);
   endtask

   task automatic pop_chk(input int d);
      int   idx;
      exp_t e;
      idx = -1;
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].dut == d) begin
            idx = i;
            break;
         end
      end
      if (idx < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_done dut%0d: got done=1 rd=%0d, want no done", d, rd_out[d]);
      end else begin
         e = sbq[idx];
         sbq.delete(idx);
         chk($sformatf("result_dut%0d_rd%0d", d, e.rd), res[d], e.res);
         chk($sformatf("rd_out_dut%0d", d), 32'(rd_out[d]), 32'(e.rd));
         if (!quiet[d]) $display("txn dut%0d rd=%0d result=%08h expected=%08h", d, rd_out[d], res[d], e.res);
      end
   endtask

   for (genvar gi = 0; gi < ND; gi++) begin : g_mon
      always @(negedge clk) begin
         if (done[gi] === 1'b1) pop_chk(gi);
      end
   end

   task automatic wait_done(input int d, input int k0, input int lat);
      bit seen;
      int k;
      seen = 1'b0;
      k    = k0;
      while (!seen && k <= 40) begin
         @(negedge clk);
         if (done[d] === 1'b1) seen = 1'b1;
         else k++;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout_dut%0d: got no done within 40 cycles, want done at cycle %0d", d, lat);
      end else begin
         chk($sformatf("latency_dut%0d", d), 32'(k), 32'(lat));
      end
   endtask

   task automatic do_op(input int d, input logic [2:0] f, input logic r, input logic [4:0] rd,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv,
                        input bit hold);
      @(posedge clk);
      #1;
      f3[d] = f; relu[d] = r; rd_in[d] = rd; a[d] = x; b[d] = y; start[d] = 1'b1;
      push_exp(d, rd, expv);
      wait_done(d, 0, (f == 3'b000 || f == 3'b001) ? 4 / lpc_of(d) + 1 : 1);
      if (!hold) begin
         @(posedge clk);
         #1;
         start[d] = 1'b0;
      end
   endtask

   task automatic seq_lpc1();
      logic [2:0]  rf;
      logic        rr;
      logic [31:0] rx, ry;
      for (int i = 0; i < 16; i++) begin
         void'(model(0, tbl[i].f3, tbl[i].relu, tbl[i].a, tbl[i].b));
         do_op(0, tbl[i].f3, tbl[i].relu, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
      end

      // Cycle-accurate stall/busy/done profile of a single DOT.
      @(posedge clk); #1;
      f3[0] = 3'b000; relu[0] = 1'b0; rd_in[0] = 5'd17; a[0] = T1A; b[0] = T1B; start[0] = 1'b1;
      push_exp(0, 5'd17, model(0, 3'b000, 1'b0, T1A, T1B));
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("stall_c%0d", c), 32'(stall[0]), 32'(c <= 4));
         chk($sformatf("busy_c%0d", c),  32'(busy[0]),  32'(c >= 1));
         chk($sformatf("done_c%0d", c),  32'(done[0]),  32'(c == 5));
      end
      @(posedge clk); #1; start[0] = 1'b0;

      // Flush in MUL must abort without touching the accumulator.
      do_op(0, 3'b010, 1'b0, 5'd18, 32'h0, 32'h0, model(0, 3'b010, 1'b0, 32'h0, 32'h0), 1'b0);
      do_op(0, 3'b001, 1'b0, 5'd19, T1A, T1B, model(0, 3'b001, 1'b0, T1A, T1B), 1'b0);
      @(posedge clk); #1; f3[0] = 3'b001; rd_in[0] = 5'd20; start[0] = 1'b1;
      @(posedge clk); #1; start[0] = 1'b0;
      @(posedge clk); #1; flush[0] = 1'b1;
      @(posedge clk); #1; flush[0] = 1'b0;
      @(negedge clk);
      chk("busy_after_flush", 32'(busy[0]), 32'd0);
      // start and flush together in IDLE: the flush wins.
      @(posedge clk); #1; start[0] = 1'b1; flush[0] = 1'b1;
      @(negedge clk);
      chk("stall_start_flush", 32'(stall[0]), 32'd0);
      @(posedge clk); #1; start[0] = 1'b0; flush[0] = 1'b0;
      @(negedge clk);
      chk("busy_start_flush", 32'(busy[0]), 32'd0);
      repeat (6) @(negedge clk);
      do_op(0, 3'b001, 1'b0, 5'd21, 32'h0, 32'h0, model(0, 3'b001, 1'b0, 32'h0, 32'h0), 1'b0);

      // Asynchronous reset in the middle of MUL.
      do_op(0, 3'b000, 1'b0, 5'd22, T1A, T1B, model(0, 3'b000, 1'b0, T1A, T1B), 1'b0);
      @(posedge clk); #1; f3[0] = 3'b001; rd_in[0] = 5'd23; start[0] = 1'b1;
      @(posedge clk); #1; start[0] = 1'b0;
      #2 rst[0] = 1'b0;
      #1;
      chk("rst_result", res[0], 32'h0);
      chk("rst_rd_out", 32'(rd_out[0]), 32'h0);
      chk("rst_busy", 32'(busy[0]), 32'h0);
      chk("rst_done", 32'(done[0]), 32'h0);
      #3 rst[0] = 1'b1;
      model_acc[0] = 0;
      do_op(0, 3'b001, 1'b0, 5'd24, T1A, T1B, model(0, 3'b001, 1'b0, T1A, T1B), 1'b0);

      // Back-to-back: start held through DONE, next instruction accepted right after.
      @(posedge clk); #1;
      f3[0] = 3'b000; relu[0] = 1'b0; rd_in[0] = 5'd25; a[0] = T1A; b[0] = T1B; start[0] = 1'b1;
      push_exp(0, 5'd25, 32'h46);
      wait_done(0, 0, 5);
      @(posedge clk); #1;
      rd_in[0] = 5'd26; a[0] = 32'h7F7F7F7F; b[0] = 32'h7F7F7F7F;
      push_exp(0, 5'd26, 32'h0000FC04);
      @(negedge clk);
      chk("b2b_stall", 32'(stall[0]), 32'd1);
      wait_done(0, 1, 5);
      @(posedge clk); #1; start[0] = 1'b0;

      for (int i = 0; i < 12; i++) begin
         rf = 3'($urandom_range(0, 7));
         rr = 1'($urandom_range(0, 1));
         rx = $urandom;
         ry = $urandom;
         do_op(0, rf, rr, 5'($urandom_range(1, 31)), rx, ry, model(0, rf, rr, rx, ry), 1'b0);
      end
   endtask

   task automatic seq_lpc2();
      logic [2:0]  rf;
      logic        rr;
      logic [31:0] rx, ry;
      do_op(1, 3'b000, 1'b0, 5'd1, T1A, T1B, 32'h00000046, 1'b0);
      for (int i = 0; i < 20; i++) begin
         rf = 3'($urandom_range(0, 3));
         rr = 1'($urandom_range(0, 1));
         rx = $urandom;
         ry = $urandom;
         do_op(1, rf, rr, 5'(i + 2), rx, ry, model(1, rf, rr, rx, ry), i != 19);
      end
   endtask

   task automatic seq_lpc4();
      do_op(2, 3'b000, 1'b0, 5'd1, 32'h80808080, 32'h7F7F7F7F, 32'hFFFF0200, 1'b0);
      do_op(2, 3'b010, 1'b0, 5'd2, 32'h0, 32'h0, model(2, 3'b010, 1'b0, 32'h0, 32'h0), 1'b0);
      quiet[2] = 1'b1;
      for (int i = 1; i <= 32769; i++) begin
         do_op(2, 3'b001, 1'b0, 5'd3, 32'h80808080, 32'h80808080,
               model(2, 3'b001, 1'b0, 32'h80808080, 32'h80808080), i != 32769);
         if (i == 32767) chk("sat_before", res[2], 32'h7FFF0000);
         if (i >= 32768) chk($sformatf("sat_%0d", i), res[2], 32'h7FFFFFFF);
      end
      quiet[2] = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{3'b000, 1'b0, 5'd1,  T1A,          T1B,          32'h00000046};
      tbl[1]  = '{3'b000, 1'b0, 5'd2,  32'h80808080, 32'h7F7F7F7F, 32'hFFFF0200};
      tbl[2]  = '{3'b000, 1'b1, 5'd3,  32'h80808080, 32'h7F7F7F7F, 32'h00000000};
      tbl[3]  = '{3'b010, 1'b0, 5'd4,  T1A,          T1B,          32'h00000000};
      tbl[4]  = '{3'b001, 1'b0, 5'd5,  T1A,          T1B,          32'd70};
      tbl[5]  = '{3'b001, 1'b0, 5'd6,  T1A,          T1B,          32'd140};
      tbl[6]  = '{3'b000, 1'b0, 5'd7,  T1A,          T1B,          32'd70};
      tbl[7]  = '{3'b001, 1'b0, 5'd8,  32'h80808080, 32'h7F7F7F7F, 32'hFFFF028C};
      tbl[8]  = '{3'b001, 1'b1, 5'd9,  32'h80808080, 32'h7F7F7F7F, 32'h00000000};
      tbl[9]  = '{3'b001, 1'b0, 5'd10, 32'h0,        32'h0,        32'hFFFE048C};
      tbl[10] = '{3'b011, 1'b0, 5'd11, T1A,          T1B,          32'h00000000};
      tbl[11] = '{3'b001, 1'b0, 5'd12, 32'h0,        32'h0,        32'hFFFE048C};
      tbl[12] = '{3'b000, 1'b0, 5'd13, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0000FC04};
      tbl[13] = '{3'b000, 1'b0, 5'd14, 32'hFF01FF01, 32'h01FF01FF, 32'hFFFFFFFC};
      tbl[14] = '{3'b010, 1'b1, 5'd15, 32'h0,        32'h0,        32'h00000000};
      tbl[15] = '{3'b000, 1'b0, 5'd16, 32'h04030201, 32'h01010101, 32'h0000000A};

      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; flush[d] = 1'b0; f3[d] = 3'b000; relu[d] = 1'b0;
         rd_in[d] = 5'd0; a[d] = 32'h0; b[d] = 32'h0; model_acc[d] = 0; quiet[d] = 1'b0;
      end
      #2;
      for (int d = 0; d < ND; d++) rst[d] = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("reset_result_dut%0d", d), res[d], 32'h0);
         chk($sformatf("reset_rd_out_dut%0d", d), 32'(rd_out[d]), 32'h0);
         chk($sformatf("reset_done_dut%0d", d), 32'(done[d]), 32'h0);
         chk($sformatf("reset_busy_dut%0d", d), 32'(busy[d]), 32'h0);
         chk($sformatf("reset_stall_dut%0d", d), 32'(stall[d]), 32'h0);
      end
      #9;
      for (int d = 0; d < ND; d++) rst[d] = 1'b1;

      fork
         seq_lpc1();
         seq_lpc2();
         seq_lpc4();
      join

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
